// File: rtl/regfile_writeback_if.sv
// Bundle of the write-back stage's producer, issue and register-file signals.
// The master side belongs to the producers/issue logic, the slave side to the stage.
interface regfile_writeback_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          ld_valid;
   logic [AW-1:0] ld_rd;
   logic [DW-1:0] ld_data;
   logic          ld_ready;

   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;

   logic          reserve_valid;
   logic [AW-1:0] reserve_rd;
   logic          reserve_ok;

   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic          rs_pending;
   logic          rt_pending;

   logic [AW-1:0] rd;
   logic [DW-1:0] input_data;
   logic          write;

   modport master (
      output ld_valid, ld_rd, ld_data,
      output alu_valid, alu_rd, alu_data,
      output reserve_valid, reserve_rd,
      output rs, rt,
      input  ld_ready, alu_ready, reserve_ok,
      input  rs_pending, rt_pending,
      input  rd, input_data, write
   );

   modport slave (
      input  ld_valid, ld_rd, ld_data,
      input  alu_valid, alu_rd, alu_data,
      input  reserve_valid, reserve_rd,
      input  rs, rt,
      output ld_ready, alu_ready, reserve_ok,
      output rs_pending, rt_pending,
      output rd, input_data, write
   );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back stage: merges load and ALU results into a small FIFO, retires at most
// one register-file write per cycle and tracks destinations with uncommitted writes
// so issue can stall on RAW hazards and refuse WAW reservations.
module regfile_writeback #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   regfile_writeback_if.slave bus
);
   localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          NREG     = 1 << AW;
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [AW-1:0]   mem_rd   [DEPTH];
   logic [DW-1:0]   mem_data [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;

   logic            full;
   logic            empty;
   logic            push_ld;
   logic            push_alu;
   logic            push;
   logic            pop;
   logic [AW-1:0]   in_rd;
   logic [DW-1:0]   in_data;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;
   logic            reserve_set;

   // Handshake decode: load wins whenever it is valid, so ALU sees not-ready then.
   always_comb begin
      full     = (count == FULL_CNT);
      empty    = (count == '0);
      push_ld  = bus.ld_valid && !full;
      push_alu = bus.alu_valid && !full && !bus.ld_valid;
      push     = push_ld || push_alu;
      pop      = !empty;
      in_rd    = push_ld ? bus.ld_rd   : bus.alu_rd;
      in_data  = push_ld ? bus.ld_data : bus.alu_data;
   end

   assign bus.ld_ready  = !full;
   assign bus.alu_ready = !full && !bus.ld_valid;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr]   <= in_rd;
         mem_data[wr_ptr] <= in_data;
      end
   end

   // Pointers, occupancy and the registered write port; the head pops every non-empty cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         bus.write      <= 1'b0;
         bus.rd         <= '0;
         bus.input_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr         <= rd_ptr + 1'b1;
            bus.write      <= (mem_rd[rd_ptr] != '0);
            bus.rd         <= mem_rd[rd_ptr];
            bus.input_data <= mem_data[rd_ptr];
         end else begin
            bus.write <= 1'b0;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Reservation is legal for r0 or for any register with no write outstanding.
   always_comb begin
      bus.reserve_ok = (bus.reserve_rd == '0) || !pending[bus.reserve_rd];
      reserve_set    = bus.reserve_valid && bus.reserve_ok && (bus.reserve_rd != '0);
      bus.rs_pending = (bus.rs != '0) && pending[bus.rs];
      bus.rt_pending = (bus.rt != '0) && pending[bus.rt];
   end

   // Next scoreboard: commit clears, reservation applied afterwards so it wins on a tie.
   always_comb begin
      pending_nxt = pending;
      if (bus.write) begin
         pending_nxt[bus.rd] = 1'b0;
      end
      if (reserve_set) begin
         pending_nxt[bus.reserve_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end
endmodule
